// File: rtl/gate_checker.sv
// gate_checker
//   Drives all four {a,b} input vectors into an external 2-input gate. Each vector
//   is held for SETTLE_CYCLES clocks, and then the gate output is sampled in one
//   further cycle and compared against TRUTH_TABLE. The block reports which vectors
//   mismatched, a saturating error count, and pass/done status.
//
// Parameters
//   SETTLE_CYCLES  clocks each vector is held before gate_f is sampled (>= 1)
//   TRUTH_TABLE    expected f per vector, bit index = {a,b}
//   CNT_W          width of err_count
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   level, only looked at in IDLE (and in DONE when looping)
//   gate_f     in   output of the gate under test
//   gate_a     out  registered gate input a (= idx[1])
//   gate_b     out  registered gate input b (= idx[0])
//   busy       out  run in progress
//   done       out  one-cycle pulse at the end of each run
//   pass       out  err_count==0, updated with done, held until the next run starts
//   err_count  out  mismatches in the current run, saturating
//   fail_vec   out  bit i set if vector i mismatched
//
// Build option
//   GATE_CHK_LOOP_EN  when defined, a start still high in DONE immediately begins
//                     another pass without clearing err_count/fail_vec.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// SETTLE  | gate inputs = idx, counting settle clocks
// SAMPLE  | compare gate_f against TRUTH_TABLE[idx], advance idx
// DONE    | one-cycle end-of-run pulse, pass updated
module gate_checker #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gate_f,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    // Guarded so an illegal SETTLE_CYCLES still elaborates far enough to report.
    localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] CNT_LAST = SET_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_checker: SETTLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       fv_q, fv_d;
    logic             loop_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fv_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    fv_d     = '0;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + SET_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (gate_f != TRUTH_TABLE[idx_q]) begin
                    fv_d[idx_q] = 1'b1;
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end
                if (idx_q == 2'd3) begin
                    state_d  = ST_DONE;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    // Uses the count including this final sample so pass is
                    // valid in the same cycle as done.
                    pass_d   = (err_d == '0);
                end else begin
                    state_d  = ST_SETTLE;
                    idx_d    = idx_q + 2'd1;
                    cnt_d    = '0;
                    gate_a_d = idx_d[1];
                    gate_b_d = idx_d[0];
                end
            end

            ST_DONE: begin
`ifdef GATE_CHK_LOOP_EN
                if (start) begin
                    state_d  = ST_SETTLE;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef GATE_CHK_LOOP_EN
    // Keeps busy high through DONE when another pass is about to follow.
    assign loop_busy = (state_q == ST_DONE) && start;
`else
    assign loop_busy = 1'b0;
`endif

    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || loop_busy;
    assign done      = (state_q == ST_DONE);
    assign gate_a    = gate_a_q;
    assign gate_b    = gate_b_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_checker.sv
module tb_gate_checker;

    localparam int         S     = 4;
    localparam logic [3:0] TRUTH = 4'b1000;
    localparam int         RUN   = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       gate_f;
    logic       gate_a, gate_b, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] fail_vec;
    logic [3:0] gate_tt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural gate under test: output looked up from its own truth table.
    assign gate_f = gate_tt[{gate_a, gate_b}];

    gate_checker #(
        .SETTLE_CYCLES (S),
        .TRUTH_TABLE   (TRUTH),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_f    (gate_f),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One run: start pulsed for a single clock, optional start pulses at
    // cycles rp0/rp1 (cycle 0 = first busy cycle) that must be ignored.
    task automatic do_run(input string tag, input logic [3:0] tt, input int rp0, input int rp1);
        int         done_c;
        int         ndone;
        logic       seq_ok;
        logic       pass_at, busy_at;
        logic [1:0] ab_at;
        logic [7:0] err_at;
        logic [3:0] fv_at, exp_fv;
        int         exp_err;

        exp_fv  = tt ^ TRUTH;
        exp_err = $countones(exp_fv);
        gate_tt = tt;
        done_c  = -1;
        ndone   = 0;
        seq_ok  = 1'b1;
        pass_at = 1'bx; busy_at = 1'bx; ab_at = 2'bxx; err_at = 'x; fv_at = 'x;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < RUN + 4; c++) begin
            if (c < RUN) begin
                if (busy !== 1'b1 || done !== 1'b0 || {gate_a, gate_b} !== 2'(c / (S + 1)))
                    seq_ok = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_c < 0) begin
                    done_c  = c;
                    pass_at = pass;
                    busy_at = busy;
                    ab_at   = {gate_a, gate_b};
                    err_at  = err_count;
                    fv_at   = fail_vec;
                end
            end
            start = (c == rp0 || c == rp1);
            @(negedge clk);
        end
        start = 1'b0;

        check($sformatf("%s_done_latency", tag), done_c, RUN);
        check($sformatf("%s_done_count", tag), ndone, 1);
        check($sformatf("%s_ab_sequence", tag), seq_ok, 1);
        check($sformatf("%s_pass", tag), pass_at, exp_err == 0);
        check($sformatf("%s_err_count", tag), err_at, exp_err);
        check($sformatf("%s_fail_vec", tag), fv_at, exp_fv);
        check($sformatf("%s_busy_at_done", tag), busy_at, 0);
        check($sformatf("%s_ab_at_done", tag), ab_at, 0);
        check($sformatf("%s_busy_after", tag), busy, 0);
        check($sformatf("%s_pass_held", tag), pass, exp_err == 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        gate_tt = TRUTH;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, pass, gate_a, gate_b, fail_vec, err_count}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", {busy, done}, 0);

        do_run("and", 4'b1000, -1, -1);
        do_run("or", 4'b1110, -1, -1);
        do_run("tied1", 4'b1111, -1, -1);
        do_run("and_again", 4'b1000, -1, -1);

        // Reset in the middle of a run with a mismatch already recorded.
        gate_tt = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_err", err_count, 1);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {busy, done, pass, gate_a, gate_b, fail_vec, err_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {busy, done, err_count}, 0);
        do_run("after_reset", 4'b1000, -1, -1);

        do_run("repulse", 4'b1000, 3, 12);

        for (int i = 0; i < 6; i++)
            do_run($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), -1, -1);

`ifdef GATE_CHK_LOOP_EN
        begin : loop_test
            int   k;
            int   prev;
            logic busy_ok;
            k       = 0;
            prev    = -1;
            busy_ok = 1'b1;
            gate_tt = 4'b0000;
            start   = 1'b1;
            @(negedge clk);
            for (int c = 0; c < 100 && k < 3; c++) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (done === 1'b1) begin
                    k++;
                    check($sformatf("loop_err_pass%0d", k), err_count, k);
                    check($sformatf("loop_fv_pass%0d", k), fail_vec, 4'b1000);
                    check($sformatf("loop_pass_flag%0d", k), pass, 0);
                    if (prev >= 0) check("loop_gap", c - prev, RUN + 1);
                    else           check("loop_first", c, RUN);
                    prev = c;
                    if (k == 3) start = 1'b0;
                end
                @(negedge clk);
            end
            check("loop_done_count", k, 3);
            check("loop_busy_held", busy_ok, 1);
            check("loop_idle_after", {busy, done}, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
